// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback arbiter
package wb_pkg;

  localparam logic WB_SRC_MEM = 1'b0;
  localparam logic WB_SRC_EX  = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  regdest;
    logic [31:0] value;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source result FIFO; pushes to a full FIFO are ignored here
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  wb_entry_t               push_data,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty,
  output wb_entry_t [DEPTH-1:0]   entries,
  output logic [DEPTH-1:0]        entry_valid
);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries_q[rd_ptr_q];
  assign count   = count_q;
  assign entries = entries_q;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push) begin
      entries_d[wr_ptr_q] = push_data;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entries_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - buffers MEM and EX results and round-robins them onto the register write port
// Optional WB_PENDING_EN adds the wb_iss_pending destination mask output.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_wb_oper,
  input  logic        mem_wb_writereg,
  input  logic [4:0]  mem_wb_regdest,
  input  logic [31:0] mem_wb_wbvalue,
  input  logic        ex_wb_oper,
  input  logic        ex_wb_writereg,
  input  logic [4:0]  ex_wb_regdest,
  input  logic [31:0] ex_wb_wbvalue,
  output logic        wb_rb_writeenable,
  output logic [4:0]  wb_rb_waddr,
  output logic [31:0] wb_rb_wdata,
  output logic        wb_iss_stall,
  output logic        wb_overflow
`ifdef WB_PENDING_EN
  ,
  output logic [31:0] wb_iss_pending
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 1 - STALL_MARGIN);

  wb_entry_t             mem_in, ex_in, mem_head, ex_head;
  logic [CW-1:0]         mem_count, ex_count;
  logic                  mem_full, ex_full, mem_empty, ex_empty;
  wb_entry_t [DEPTH-1:0] mem_entries, ex_entries;
  logic [DEPTH-1:0]      mem_ev, ex_ev;
  logic                  mem_push, ex_push, grant_mem, grant_ex;

  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        overflow_q, overflow_d;

  // Results to $0 are architecturally void and never enter a FIFO.
  assign mem_push = mem_wb_oper && mem_wb_writereg && (mem_wb_regdest != REG_ZERO);
  assign ex_push  = ex_wb_oper && ex_wb_writereg && (ex_wb_regdest != REG_ZERO);
  assign mem_in   = '{regdest: mem_wb_regdest, value: mem_wb_wbvalue};
  assign ex_in    = '{regdest: ex_wb_regdest, value: ex_wb_wbvalue};

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clock(clock), .reset(reset), .push(mem_push), .push_data(mem_in), .pop(grant_mem),
    .head(mem_head), .count(mem_count), .full(mem_full), .empty(mem_empty),
    .entries(mem_entries), .entry_valid(mem_ev)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_ex_fifo (
    .clock(clock), .reset(reset), .push(ex_push), .push_data(ex_in), .pop(grant_ex),
    .head(ex_head), .count(ex_count), .full(ex_full), .empty(ex_empty),
    .entries(ex_entries), .entry_valid(ex_ev)
  );

  // last_grant only moves on a tie; a lone requester does not disturb fairness.
  always_comb begin
    grant_mem    = 1'b0;
    grant_ex     = 1'b0;
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    overflow_d   = overflow_q || (mem_push && mem_full) || (ex_push && ex_full);
    if (!mem_empty && (ex_empty || last_grant_q == WB_SRC_EX)) begin
      grant_mem = 1'b1;
    end else if (!ex_empty) begin
      grant_ex = 1'b1;
    end
    if (!mem_empty && !ex_empty) begin
      last_grant_d = grant_mem ? WB_SRC_MEM : WB_SRC_EX;
    end
    if (grant_mem) begin
      we_d    = 1'b1;
      waddr_d = mem_head.regdest;
      wdata_d = mem_head.value;
    end else if (grant_ex) begin
      we_d    = 1'b1;
      waddr_d = ex_head.regdest;
      wdata_d = ex_head.value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= WB_SRC_EX;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wb_rb_writeenable = we_q;
  assign wb_rb_waddr       = waddr_q;
  assign wb_rb_wdata       = wdata_q;
  assign wb_overflow       = overflow_q;
  assign wb_iss_stall      = (mem_count > STALL_TH) || (ex_count > STALL_TH);

`ifdef WB_PENDING_EN
  always_comb begin
    wb_iss_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_ev[i]) wb_iss_pending[mem_entries[i].regdest] = 1'b1;
      if (ex_ev[i])  wb_iss_pending[ex_entries[i].regdest] = 1'b1;
    end
    if (we_q) wb_iss_pending[waddr_q] = 1'b1;
    wb_iss_pending[0] = 1'b0;
  end
`else
  logic unused_entries;
  assign unused_entries = ^{mem_entries, ex_entries, mem_ev, ex_ev};
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized self-checking bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;

  localparam int DEPTH        = 4;
  localparam int STALL_MARGIN = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_wb_oper = 0, mem_wb_writereg = 0;
  logic [4:0]  mem_wb_regdest = 0;
  logic [31:0] mem_wb_wbvalue = 0;
  logic        ex_wb_oper = 0, ex_wb_writereg = 0;
  logic [4:0]  ex_wb_regdest = 0;
  logic [31:0] ex_wb_wbvalue = 0;
  logic        wb_rb_writeenable, wb_iss_stall, wb_overflow;
  logic [4:0]  wb_rb_waddr;
  logic [31:0] wb_rb_wdata;
`ifdef WB_PENDING_EN
  logic [31:0] wb_iss_pending;
`endif

  wb_arbiter #(.DEPTH(DEPTH), .STALL_MARGIN(STALL_MARGIN)) dut (
    .clock(clock), .reset(reset),
    .mem_wb_oper(mem_wb_oper), .mem_wb_writereg(mem_wb_writereg),
    .mem_wb_regdest(mem_wb_regdest), .mem_wb_wbvalue(mem_wb_wbvalue),
    .ex_wb_oper(ex_wb_oper), .ex_wb_writereg(ex_wb_writereg),
    .ex_wb_regdest(ex_wb_regdest), .ex_wb_wbvalue(ex_wb_wbvalue),
    .wb_rb_writeenable(wb_rb_writeenable), .wb_rb_waddr(wb_rb_waddr),
    .wb_rb_wdata(wb_rb_wdata), .wb_iss_stall(wb_iss_stall), .wb_overflow(wb_overflow)
`ifdef WB_PENDING_EN
    , .wb_iss_pending(wb_iss_pending)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: each source is a plain queue of {regdest, value}.
  logic [36:0] mq[$];
  logic [36:0] eq[$];
  logic        m_last_ex = 1'b1;
  logic        m_we = 0, m_ovf = 0;
  logic [4:0]  m_waddr = 0;
  logic [31:0] m_wdata = 0;

  function automatic logic m_stall();
    return (mq.size() > DEPTH - 1 - STALL_MARGIN) || (eq.size() > DEPTH - 1 - STALL_MARGIN);
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i][36:32]] = 1'b1;
    foreach (eq[i]) p[eq[i][36:32]] = 1'b1;
    if (m_we) p[m_waddr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_edge();
    int          msz, esz;
    logic [36:0] e;
    if (reset) begin
      mq.delete(); eq.delete();
      m_last_ex = 1'b1; m_we = 0; m_waddr = 0; m_wdata = 0; m_ovf = 0;
      return;
    end
    msz = mq.size();
    esz = eq.size();
    m_we = 0;
    if (msz > 0 && (esz == 0 || m_last_ex)) begin
      e = mq.pop_front(); m_we = 1; m_waddr = e[36:32]; m_wdata = e[31:0];
      if (esz > 0) m_last_ex = 1'b0;
    end else if (esz > 0) begin
      e = eq.pop_front(); m_we = 1; m_waddr = e[36:32]; m_wdata = e[31:0];
      if (msz > 0) m_last_ex = 1'b1;
    end
    if (mem_wb_oper && mem_wb_writereg && mem_wb_regdest != 0) begin
      if (msz == DEPTH) m_ovf = 1; else mq.push_back({mem_wb_regdest, mem_wb_wbvalue});
    end
    if (ex_wb_oper && ex_wb_writereg && ex_wb_regdest != 0) begin
      if (esz == DEPTH) m_ovf = 1; else eq.push_back({ex_wb_regdest, ex_wb_wbvalue});
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    mem_wb_oper = 0; mem_wb_writereg = 0; mem_wb_regdest = 0; mem_wb_wbvalue = 0;
    ex_wb_oper = 0; ex_wb_writereg = 0; ex_wb_regdest = 0; ex_wb_wbvalue = 0;
  endtask

  task automatic drive_mem(input logic [4:0] r, input logic [31:0] v);
    mem_wb_oper = 1; mem_wb_writereg = 1; mem_wb_regdest = r; mem_wb_wbvalue = v;
  endtask

  task automatic drive_ex(input logic [4:0] r, input logic [31:0] v);
    ex_wb_oper = 1; ex_wb_writereg = 1; ex_wb_regdest = r; ex_wb_wbvalue = v;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    n_cmp++;
    if ({wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata, wb_iss_stall, wb_overflow} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_state: got we=%0b a=%0d d=%h st=%0b ov=%0b, want all zero",
               wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata, wb_iss_stall, wb_overflow);
    end
    reset = 0;
  endtask

  task automatic test_single_mem();
    pulse_reset();
    drive_mem(5'd5, 32'hDEADBEEF);
    step();
    idle_inputs();
    n_cmp++;
    if (wb_rb_writeenable !== 1'b0) begin
      n_fail++; $display("FAIL single_c2_we: got %0b want 0", wb_rb_writeenable);
    end
    step();
    n_cmp++;
    if ({wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_c3_write: got we=%0b a=%0d d=%h want we=1 a=5 d=deadbeef",
               wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata);
    end
    step();
    n_cmp++;
    if ({wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL single_c4_hold: got we=%0b a=%0d d=%h want we=0 a=5 d=deadbeef",
               wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata);
    end
  endtask

  task automatic test_alternate();
    logic [4:0] exp_order[6];
    logic [4:0] seen[$];
    int         first_c = -1, last_c = -1;
    exp_order = '{5'd1, 5'd4, 5'd2, 5'd5, 5'd3, 5'd6};
    pulse_reset();
    for (int c = 0; c < 11; c++) begin
      idle_inputs();
      if (c < 3) begin
        drive_mem(5'(c + 1), 32'(8'h11 * (c + 1)));
        drive_ex(5'(c + 4), 32'(8'h11 * (c + 4)));
      end
      step();
      n_cmp++;
      if ({wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata, wb_iss_stall, wb_overflow} !==
          {m_we, m_waddr, m_wdata, m_stall(), m_ovf}) begin
        n_fail++;
        $display("FAIL alternate_c%0d: got we=%0b a=%0d d=%h st=%0b ov=%0b want we=%0b a=%0d d=%h st=%0b ov=%0b",
                 c, wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata, wb_iss_stall, wb_overflow,
                 m_we, m_waddr, m_wdata, m_stall(), m_ovf);
      end
      if (wb_rb_writeenable === 1'b1) begin
        seen.push_back(wb_rb_waddr);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    n_cmp++;
    if (seen.size() != 6 || last_c - first_c != 5) begin
      n_fail++;
      $display("FAIL alternate_count: got %0d writes over %0d cycles want 6 over 6",
               seen.size(), last_c - first_c + 1);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (seen[i] !== exp_order[i]) begin
          n_fail++;
          $display("FAIL alternate_order[%0d]: got r%0d want r%0d", i, seen[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_zero_filter();
    pulse_reset();
    drive_ex(5'd0, 32'h1234);
    for (int c = 0; c < 4; c++) begin
      step();
      idle_inputs();
      n_cmp++;
      if ({wb_rb_writeenable, wb_iss_stall, wb_overflow} !== 3'b000) begin
        n_fail++;
        $display("FAIL zero_filter_c%0d: got we=%0b st=%0b ov=%0b want 0 0 0",
                 c, wb_rb_writeenable, wb_iss_stall, wb_overflow);
      end
    end
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int c = 0; c < 30; c++) begin
      idle_inputs();
      if (c < 4) drive_mem(5'($urandom_range(1, 31)), $urandom);
      if (c < 10) drive_ex(5'($urandom_range(1, 31)), $urandom);
      step();
      n_cmp++;
      if ({wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata, wb_iss_stall, wb_overflow} !==
          {m_we, m_waddr, m_wdata, m_stall(), m_ovf}) begin
        n_fail++;
        $display("FAIL overflow_c%0d: got we=%0b a=%0d d=%h st=%0b ov=%0b want we=%0b a=%0d d=%h st=%0b ov=%0b",
                 c, wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata, wb_iss_stall, wb_overflow,
                 m_we, m_waddr, m_wdata, m_stall(), m_ovf);
      end
      if (c == 0) begin
        n_cmp++;
        if (wb_iss_stall !== 1'b1) begin
          n_fail++; $display("FAIL stall_rise: got %0b want 1", wb_iss_stall);
        end
      end
    end
    n_cmp++;
    if ({wb_overflow, wb_rb_writeenable, wb_iss_stall} !== 3'b100) begin
      n_fail++;
      $display("FAIL overflow_sticky: got ov=%0b we=%0b st=%0b want ov=1 we=0 st=0",
               wb_overflow, wb_rb_writeenable, wb_iss_stall);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      drive_mem(5'(10 + c), $urandom);
      step();
    end
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({wb_rb_writeenable, wb_iss_stall, wb_overflow} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_c%0d: got we=%0b st=%0b ov=%0b want 0 0 0",
                 c, wb_rb_writeenable, wb_iss_stall, wb_overflow);
      end
      step();
    end
  endtask

`ifdef WB_PENDING_EN
  task automatic test_pending();
    logic [2:0] exp_bits;
    pulse_reset();
    drive_mem(5'd7, 32'hCAFE0007);
    exp_bits = 3'b110;
    for (int c = 0; c < 3; c++) begin
      step();
      idle_inputs();
      n_cmp++;
      if (wb_iss_pending[7] !== exp_bits[2 - c]) begin
        n_fail++;
        $display("FAIL pending_r7_c%0d: got %0b want %0b", c + 2, wb_iss_pending[7], exp_bits[2 - c]);
      end
    end
  endtask
`endif

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 300; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      mem_wb_oper = ($urandom_range(0, 2) == 0);
      mem_wb_writereg = ($urandom_range(0, 5) != 0);
      mem_wb_regdest = 5'($urandom_range(0, 31));
      mem_wb_wbvalue = $urandom;
      ex_wb_oper = ($urandom_range(0, 2) == 0);
      ex_wb_writereg = ($urandom_range(0, 5) != 0);
      ex_wb_regdest = 5'($urandom_range(0, 31));
      ex_wb_wbvalue = $urandom;
      step();
      n_cmp++;
      if ({wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata, wb_iss_stall, wb_overflow} !==
          {m_we, m_waddr, m_wdata, m_stall(), m_ovf}) begin
        n_fail++;
        $display("FAIL random_c%0d: got we=%0b a=%0d d=%h st=%0b ov=%0b want we=%0b a=%0d d=%h st=%0b ov=%0b",
                 c, wb_rb_writeenable, wb_rb_waddr, wb_rb_wdata, wb_iss_stall, wb_overflow,
                 m_we, m_waddr, m_wdata, m_stall(), m_ovf);
      end
`ifdef WB_PENDING_EN
      n_cmp++;
      if (wb_iss_pending !== m_pending()) begin
        n_fail++;
        $display("FAIL random_pending_c%0d: got %h want %h", c, wb_iss_pending, m_pending());
      end
`endif
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_mem();
    test_alternate();
    test_zero_filter();
    test_overflow();
    test_reset_mid();
`ifdef WB_PENDING_EN
    test_pending();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side receiver for the memory stage's mem_wb_* outputs and for the execute unit's result bus.
- Buffers both result streams in per-source FIFOs.
- Arbitrates round-robin onto the single register-bank write port.
- Raises a stall toward Issue before either FIFO can overflow, because neither Mem nor Execute accepts backpressure.

Parameters:
- DEPTH, 4: entries per source FIFO; power of two, minimum 4.
- STALL_MARGIN, 3: free-entry threshold for stall; covers the issue, m0 and m1 results already in flight.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- mem_wb_oper  in  1  memory-stage result valid
- mem_wb_writereg  in  1  memory result targets a register
- mem_wb_regdest  in  5  memory destination register
- mem_wb_wbvalue  in  32  memory writeback data
- ex_wb_oper  in  1  execute result valid
- ex_wb_writereg  in  1  execute result targets a register
- ex_wb_regdest  in  5  execute destination register
- ex_wb_wbvalue  in  32  execute writeback data
- wb_rb_writeenable  out  1  register-bank write strobe
- wb_rb_waddr  out  5  register-bank write address
- wb_rb_wdata  out  32  register-bank write data
- wb_iss_stall  out  1  Issue must not launch new operations
- wb_overflow  out  1  sticky error flag: a push was dropped
- wb_iss_pending  out  32  pending-destination mask; only when WB_PENDING_EN is defined

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - FIFOs empty and counts 0.
  - last_grant = EX, so MEM wins the first tie.
  - wb_rb_writeenable = 0, wb_rb_waddr = 0, wb_rb_wdata = 0.
  - wb_overflow = 0, wb_iss_stall = 0.
- Reset mid-operation discards all buffered entries. No write occurs in the cycle after reset.
- Push qualification, per source:
  - Push when oper && writereg && regdest != 0.
  - Writes to $0 are dropped silently; they never set wb_overflow.
- Push on a full FIFO: the entry is dropped, wb_overflow is set, and it stays set until reset.
- Arbitration, evaluated each edge over the FIFO heads as they stood before that edge:
  - Neither head valid: wb_rb_writeenable <= 0. waddr and wdata hold their previous values.
  - One head valid: grant it.
  - Both heads valid: grant the source not equal to last_grant, then update last_grant.
  - The granted head is popped, and its regdest/value are registered onto wb_rb_* with writeenable <= 1.
- Latency: an input valid in cycle N is enqueued at the end of N, popped at the end of N+1 if granted, and is on wb_rb_* during N+2. Minimum latency is 2 cycles.
- Push to an empty FIFO is never popped in the same edge.
- Simultaneous push and pop on one FIFO: both take effect and the count is unchanged.
- Ordering: per-source FIFO order is preserved. No ordering is guaranteed between sources; Issue owns hazards between them.
- Stall: wb_iss_stall = (count_mem > DEPTH-1-STALL_MARGIN) || (count_ex > DEPTH-1-STALL_MARGIN), computed combinationally from registered counts.
- Pointers: wrap modulo DEPTH. count width is clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: WB_PENDING_EN.
- Defined:
  - Output wb_iss_pending[r] = 1 while register r is in any valid FIFO entry, or is in the wb_rb_* register while writeenable = 1.
  - Bit 0 is always 0.
  - Combinational OR over the entries. Issue uses the mask for RAW interlock.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - WB_SRC_MEM = 1'b0 and WB_SRC_EX = 1'b1.
  - wb_entry_t {regdest[4:0], value[31:0]}, 37 bits.
  - REG_ZERO = 5'd0.
- One sub-module, wb_fifo (parameter DEPTH), instantiated twice. It provides push, pop, head, count, full and empty, and exposes its entry array for the pending mask.

Test Plan:
- Single MEM result: mem oper=1, writereg=1, regdest=5, wbvalue=0xDEADBEEF in cycle 1 -> in cycle 3 writeenable=1, waddr=5, wdata=0xDEADBEEF; writeenable=0 in cycle 4.
- Simultaneous sources, repeated for 3 cycles: MEM r1..r3 = 0x11,0x22,0x33 and EX r4..r6 = 0x44,0x55,0x66 -> writes alternate r1,r4,r2,r5,r3,r6 over 6 consecutive cycles, each source in FIFO order.
- $0 filter: EX result with regdest=0, value=0x1234 -> no write, count_ex stays 0, wb_overflow stays 0.
- Stall/overflow with DEPTH=4, STALL_MARGIN=3:
  - Both sources valid every cycle -> stall rises once count reaches 1.
  - Keep driving EX for 6 cycles while ignoring stall -> wb_overflow=1; remaining entries drain intact.
- Reset mid-drain: 3 MEM entries queued, reset for 1 cycle -> no writes in the following cycles, stall=0, overflow=0.
- WB_PENDING_EN: MEM r7 enqueued -> pending[7]=1 from cycle 2 through cycle 3 inclusive, and 0 in cycle 4.
